// File: rtl/iob_uart_console_bridge.sv
// -----------------------------------------------------------------------------
// iob_uart_console_bridge
//
// Self-contained console endpoint for the simulation UART (iob_uart). It acts
// as the IOb-native master of that UART: after reset it runs a fixed
// initialisation write sequence, then alternates forever between polling the
// receiver (received bytes are buffered in a small RX FIFO) and polling the
// transmitter (bytes offered on the tx stream are written to TXDATA).
//
// Ports
//   clk_i          system clock
//   rst_i          asynchronous, active-high reset
//   iob_avalid_o   request valid to the UART (held until accepted)
//   iob_addr_o     byte address
//   iob_wdata_o    write data, byte placed in lane addr[1:0]
//   iob_wstrb_o    write strobe, 4'b0000 marks a read
//   iob_rdata_i    read data
//   iob_ready_i    request accepted
//   iob_rvalid_i   read data valid
//   tx_data_i      byte to transmit
//   tx_valid_i     tx byte offered
//   tx_ready_o     tx byte consumed (single-cycle pulse)
//   rx_data_o      RX FIFO head byte
//   rx_valid_o     RX FIFO not empty
//   rx_ready_i     pop RX FIFO head
//   init_done_o    initialisation sequence complete (sticky until reset)
// -----------------------------------------------------------------------------
module iob_uart_console_bridge #(
    parameter int          ADDR_W         = 3,
    parameter int          DATA_W         = 32,
    parameter logic [15:0] DIV            = 16'd16,
    parameter int          RX_FIFO_W      = 2,
    parameter int          SOFTRESET_ADDR = 0,
    parameter int          DIV_ADDR       = 2,
    parameter int          TXDATA_ADDR    = 4,
    parameter int          TXEN_ADDR      = 5,
    parameter int          RXEN_ADDR      = 6,
    parameter int          TXREADY_ADDR   = 0,
    parameter int          RXREADY_ADDR   = 1,
    parameter int          RXDATA_ADDR    = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              iob_avalid_o,
    output logic [ADDR_W-1:0] iob_addr_o,
    output logic [DATA_W-1:0] iob_wdata_o,
    output logic [3:0]        iob_wstrb_o,
    input  logic [DATA_W-1:0] iob_rdata_i,
    input  logic              iob_ready_i,
    input  logic              iob_rvalid_i,
    input  logic [7:0]        tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [7:0]        rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic              init_done_o
);

    localparam int                 DEPTH   = 1 << RX_FIFO_W;
    localparam logic [RX_FIFO_W:0] DEPTH_L = (RX_FIFO_W + 1)'(DEPTH);

    localparam logic [ADDR_W-1:0] A_SRST   = ADDR_W'(SOFTRESET_ADDR);
    localparam logic [ADDR_W-1:0] A_DIV    = ADDR_W'(DIV_ADDR);
    localparam logic [ADDR_W-1:0] A_TXDATA = ADDR_W'(TXDATA_ADDR);
    localparam logic [ADDR_W-1:0] A_TXEN   = ADDR_W'(TXEN_ADDR);
    localparam logic [ADDR_W-1:0] A_RXEN   = ADDR_W'(RXEN_ADDR);
    localparam logic [ADDR_W-1:0] A_TXRDY  = ADDR_W'(TXREADY_ADDR);
    localparam logic [ADDR_W-1:0] A_RXRDY  = ADDR_W'(RXREADY_ADDR);
    localparam logic [ADDR_W-1:0] A_RXDATA = ADDR_W'(RXDATA_ADDR);

    typedef enum logic [3:0] {
        INIT_SRST1  = 4'd0,
        INIT_SRST0  = 4'd1,
        INIT_DIV    = 4'd2,
        INIT_TXEN   = 4'd3,
        INIT_RXEN   = 4'd4,
        POLL_RX     = 4'd5,
        RXRDY_WAIT  = 4'd6,
        RD_RX       = 4'd7,
        RD_RX_WAIT  = 4'd8,
        POLL_TX     = 4'd9,
        TXRDY_WAIT  = 4'd10,
        WR_TX       = 4'd11
    } state_t;

    // Byte placed in its 32-bit lane.
    function automatic logic [DATA_W-1:0] lane_wdata(input logic [7:0] b, input logic [1:0] lane);
        return {{(DATA_W - 8){1'b0}}, b} << {lane, 3'b000};
    endfunction

    // Single-byte write strobe for a lane.
    function automatic logic [3:0] lane_wstrb(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

    // Byte extracted from its 32-bit lane.
    function automatic logic [7:0] lane_rdata(input logic [DATA_W-1:0] d, input logic [1:0] lane);
        return d[{lane, 3'b000} +: 8];
    endfunction

    state_t              state_q, state_d;
    logic                avalid_q, avalid_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic [7:0]          tx_byte_q, tx_byte_d;
    logic                init_done_q, init_done_d;

    logic [7:0]          fifo_mem_q [DEPTH];
    logic [RX_FIFO_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [RX_FIFO_W:0]  level_q, level_d;

    logic                push_s;
    logic                pop_s;
    logic                tx_ready_s;
    logic [7:0]          rsp_byte_s;

    // The read response lane follows the address still held from the request.
    assign rsp_byte_s = lane_rdata(iob_rdata_i, addr_q[1:0]);
    assign pop_s      = rx_valid_o & rx_ready_i;

    // Next-state, bus request and stream handshake logic.
    // A request is raised only when avalid_q is low in a bus state; after
    // acceptance the FSM always leaves that state, so avalid is low for at
    // least one cycle between consecutive requests.
    always_comb begin
        state_d     = state_q;
        avalid_d    = avalid_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        tx_byte_d   = tx_byte_q;
        init_done_d = init_done_q;
        push_s      = 1'b0;
        tx_ready_s  = 1'b0;

        case (state_q)
            INIT_SRST1: begin
                if (!avalid_q) begin
                    avalid_d = 1'b1;
                    addr_d   = A_SRST;
                    wdata_d  = lane_wdata(8'h01, A_SRST[1:0]);
                    wstrb_d  = lane_wstrb(A_SRST[1:0]);
                end else if (iob_ready_i) begin
                    avalid_d = 1'b0;
                    state_d  = INIT_SRST0;
                end else begin
                    avalid_d = 1'b1;
                end
            end
            INIT_SRST0: begin
                if (!avalid_q) begin
                    avalid_d = 1'b1;
                    addr_d   = A_SRST;
                    wdata_d  = lane_wdata(8'h00, A_SRST[1:0]);
                    wstrb_d  = lane_wstrb(A_SRST[1:0]);
                end else if (iob_ready_i) begin
                    avalid_d = 1'b0;
                    state_d  = INIT_DIV;
                end else begin
                    avalid_d = 1'b1;
                end
            end
            INIT_DIV: begin
                // The divisor register spans the upper half-word.
                if (!avalid_q) begin
                    avalid_d = 1'b1;
                    addr_d   = A_DIV;
                    wdata_d  = DATA_W'({DIV, 16'h0000});
                    wstrb_d  = 4'b1100;
                end else if (iob_ready_i) begin
                    avalid_d = 1'b0;
                    state_d  = INIT_TXEN;
                end else begin
                    avalid_d = 1'b1;
                end
            end
            INIT_TXEN: begin
                if (!avalid_q) begin
                    avalid_d = 1'b1;
                    addr_d   = A_TXEN;
                    wdata_d  = lane_wdata(8'h01, A_TXEN[1:0]);
                    wstrb_d  = lane_wstrb(A_TXEN[1:0]);
                end else if (iob_ready_i) begin
                    avalid_d = 1'b0;
                    state_d  = INIT_RXEN;
                end else begin
                    avalid_d = 1'b1;
                end
            end
            INIT_RXEN: begin
                if (!avalid_q) begin
                    avalid_d = 1'b1;
                    addr_d   = A_RXEN;
                    wdata_d  = lane_wdata(8'h01, A_RXEN[1:0]);
                    wstrb_d  = lane_wstrb(A_RXEN[1:0]);
                end else if (iob_ready_i) begin
                    avalid_d    = 1'b0;
                    init_done_d = 1'b1;
                    state_d     = POLL_RX;
                end else begin
                    avalid_d = 1'b1;
                end
            end
            POLL_RX: begin
                // Only poll when the FIFO can take a byte, so a push never
                // lands in a full FIFO.
                if (!avalid_q) begin
                    if (level_q < DEPTH_L) begin
                        avalid_d = 1'b1;
                        addr_d   = A_RXRDY;
                        wdata_d  = '0;
                        wstrb_d  = 4'b0000;
                    end else begin
                        state_d = POLL_TX;
                    end
                end else if (iob_ready_i) begin
                    avalid_d = 1'b0;
                    if (iob_rvalid_i) begin
                        state_d = rsp_byte_s[0] ? RD_RX : POLL_TX;
                    end else begin
                        state_d = RXRDY_WAIT;
                    end
                end else begin
                    avalid_d = 1'b1;
                end
            end
            RXRDY_WAIT: begin
                if (iob_rvalid_i) begin
                    state_d = rsp_byte_s[0] ? RD_RX : POLL_TX;
                end else begin
                    state_d = RXRDY_WAIT;
                end
            end
            RD_RX: begin
                if (!avalid_q) begin
                    avalid_d = 1'b1;
                    addr_d   = A_RXDATA;
                    wdata_d  = '0;
                    wstrb_d  = 4'b0000;
                end else if (iob_ready_i) begin
                    avalid_d = 1'b0;
                    if (iob_rvalid_i) begin
                        push_s  = 1'b1;
                        state_d = POLL_TX;
                    end else begin
                        state_d = RD_RX_WAIT;
                    end
                end else begin
                    avalid_d = 1'b1;
                end
            end
            RD_RX_WAIT: begin
                if (iob_rvalid_i) begin
                    push_s  = 1'b1;
                    state_d = POLL_TX;
                end else begin
                    state_d = RD_RX_WAIT;
                end
            end
            POLL_TX: begin
                // Without an offered byte the bus is left idle this turn.
                if (!avalid_q) begin
                    if (tx_valid_i) begin
                        avalid_d = 1'b1;
                        addr_d   = A_TXRDY;
                        wdata_d  = '0;
                        wstrb_d  = 4'b0000;
                    end else begin
                        state_d = POLL_RX;
                    end
                end else if (iob_ready_i) begin
                    avalid_d = 1'b0;
                    if (iob_rvalid_i) begin
                        if (rsp_byte_s[0] && tx_valid_i) begin
                            tx_ready_s = 1'b1;
                            tx_byte_d  = tx_data_i;
                            state_d    = WR_TX;
                        end else begin
                            state_d = POLL_RX;
                        end
                    end else begin
                        state_d = TXRDY_WAIT;
                    end
                end else begin
                    avalid_d = 1'b1;
                end
            end
            TXRDY_WAIT: begin
                // The byte is only taken if it is still offered when the
                // transmitter reports ready.
                if (iob_rvalid_i) begin
                    if (rsp_byte_s[0] && tx_valid_i) begin
                        tx_ready_s = 1'b1;
                        tx_byte_d  = tx_data_i;
                        state_d    = WR_TX;
                    end else begin
                        state_d = POLL_RX;
                    end
                end else begin
                    state_d = TXRDY_WAIT;
                end
            end
            WR_TX: begin
                if (!avalid_q) begin
                    avalid_d = 1'b1;
                    addr_d   = A_TXDATA;
                    wdata_d  = lane_wdata(tx_byte_q, A_TXDATA[1:0]);
                    wstrb_d  = lane_wstrb(A_TXDATA[1:0]);
                end else if (iob_ready_i) begin
                    avalid_d = 1'b0;
                    state_d  = POLL_RX;
                end else begin
                    avalid_d = 1'b1;
                end
            end
            default: begin
                avalid_d = 1'b0;
                state_d  = INIT_SRST1;
            end
        endcase
    end

    // FSM state and registered bus request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= INIT_SRST1;
            avalid_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= 4'b0000;
            tx_byte_q   <= 8'h00;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            avalid_q    <= avalid_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            tx_byte_q   <= tx_byte_d;
            init_done_q <= init_done_d;
        end
    end

    // FIFO occupancy: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + (RX_FIFO_W + 1)'(1);
            2'b01:   level_d = level_q - (RX_FIFO_W + 1)'(1);
            default: level_d = level_q;
        endcase
    end

    // RX FIFO storage and pointers (pointers wrap modulo the depth).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem_q[i] <= 8'h00;
            end
        end else begin
            level_q <= level_d;
            if (push_s) begin
                fifo_mem_q[wr_ptr_q] <= rsp_byte_s;
                wr_ptr_q             <= wr_ptr_q + RX_FIFO_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + RX_FIFO_W'(1);
            end
        end
    end

    assign iob_avalid_o = avalid_q;
    assign iob_addr_o   = addr_q;
    assign iob_wdata_o  = wdata_q;
    assign iob_wstrb_o  = wstrb_q;
    assign tx_ready_o   = tx_ready_s;
    assign rx_data_o    = fifo_mem_q[rd_ptr_q];
    assign rx_valid_o   = (level_q != '0);
    assign init_done_o  = init_done_q;

endmodule

// File: tb/tb_iob_uart_console_bridge.sv
// -----------------------------------------------------------------------------
// Testbench for iob_uart_console_bridge. A behavioural UART model answers the
// bridge's IOb requests (ready combinational, rvalid one cycle after
// acceptance) and logs every accepted write. Expected writes and expected RX
// bytes are queued when stimulus is applied and compared as the DUT produces
// them.
// -----------------------------------------------------------------------------
module tb_iob_uart_console_bridge;

    typedef struct packed {
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iob_avalid;
    logic [2:0]  iob_addr;
    logic [31:0] iob_wdata;
    logic [3:0]  iob_wstrb;
    logic [31:0] iob_rdata;
    logic        iob_ready;
    logic        iob_rvalid;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic        init_done;

    int checks = 0;
    int failures = 0;

    wr_t        exp_wr[$];
    wr_t        obs_wr[$];
    logic [7:0] rx_src[$];
    logic [7:0] exp_rx[$];
    logic       txrdy_script[$];

    logic [31:0] rdata_q = 32'h0;
    logic        rvalid_q = 1'b0;
    int          stall_target = 0;
    int          stall_used = 0;
    int          stall_left;
    int          n_rxrdy = 0;
    int          n_rxdata = 0;
    int          n_txrdy = 0;
    int          n_txpulse = 0;

    always #5 clk = ~clk;

    iob_uart_console_bridge dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .iob_avalid_o (iob_avalid),
        .iob_addr_o   (iob_addr),
        .iob_wdata_o  (iob_wdata),
        .iob_wstrb_o  (iob_wstrb),
        .iob_rdata_i  (iob_rdata),
        .iob_ready_i  (iob_ready),
        .iob_rvalid_i (iob_rvalid),
        .tx_data_i    (tx_data),
        .tx_valid_i   (tx_valid),
        .tx_ready_o   (tx_ready),
        .rx_data_o    (rx_data),
        .rx_valid_o   (rx_valid),
        .rx_ready_i   (rx_ready),
        .init_done_o  (init_done)
    );

    // UART model: writes can be stalled for a programmed number of cycles.
    assign stall_left = stall_target - stall_used;
    assign iob_ready  = !(iob_avalid && (iob_wstrb != 4'b0000) && (stall_left != 0));
    assign iob_rvalid = rvalid_q;
    assign iob_rdata  = rdata_q;

    // UART model register file; unused lanes carry values that would flip
    // the decision if the wrong lane were sampled.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            rvalid_q <= 1'b0;
            if (iob_avalid && (iob_wstrb != 4'b0000) && (stall_left != 0))
                stall_used <= stall_used + 1;
            if (iob_avalid && iob_ready) begin
                if (iob_wstrb != 4'b0000) begin
                    obs_wr.push_back({iob_addr, iob_wdata, iob_wstrb});
                end else begin
                    rvalid_q <= 1'b1;
                    case (iob_addr)
                        3'd1: begin
                            n_rxrdy <= n_rxrdy + 1;
                            rdata_q <= {16'h0000, 7'h00, (rx_src.size() != 0), 8'h01};
                        end
                        3'd4: begin
                            n_rxdata <= n_rxdata + 1;
                            rdata_q  <= {24'hFFFFFF, ((rx_src.size() != 0) ? rx_src.pop_front() : 8'hEE)};
                        end
                        3'd0: begin
                            n_txrdy <= n_txrdy + 1;
                            rdata_q <= {16'h0000, 8'hFF, 7'h00,
                                        ((txrdy_script.size() != 0) ? txrdy_script.pop_front() : 1'b0)};
                        end
                        default: rdata_q <= 32'hDEADBEEF;
                    endcase
                end
            end
        end
    end

    // Count tx_ready pulses (one sample per cycle).
    always @(negedge clk) begin
        if (tx_ready === 1'b1) n_txpulse <= n_txpulse + 1;
    end

    task automatic push_init_expect();
        exp_wr.push_back({3'd0, 32'h00000001, 4'b0001});
        exp_wr.push_back({3'd0, 32'h00000000, 4'b0001});
        exp_wr.push_back({3'd2, 32'h00100000, 4'b1100});
        exp_wr.push_back({3'd5, 32'h00000100, 4'b0010});
        exp_wr.push_back({3'd6, 32'h00010000, 4'b0100});
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({iob_avalid, iob_addr, iob_wdata, iob_wstrb} !== 40'h0) begin
            failures++;
            $display("FAIL reset_bus: got avalid=%0b addr=%0h wdata=%0h wstrb=%0h, want all 0",
                     iob_avalid, iob_addr, iob_wdata, iob_wstrb);
        end
        checks++;
        if ({tx_ready, rx_valid, rx_data, init_done} !== 11'h0) begin
            failures++;
            $display("FAIL reset_stream: got tx_ready=%0b rx_valid=%0b rx_data=%0h init_done=%0b, want all 0",
                     tx_ready, rx_valid, rx_data, init_done);
        end
    endtask

    task automatic test_init(input string tag);
        int  k;
        wr_t o, e;
        obs_wr.delete();
        push_init_expect();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (init_done !== 1'b0) begin
            failures++;
            $display("FAIL %s_done_early: got %0b want 0", tag, init_done);
        end
        k = 0;
        while (obs_wr.size() < 5 && k < 200) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (obs_wr.size() < 5) begin
            failures++;
            $display("FAIL %s_timeout: got %0d writes want 5", tag, obs_wr.size());
        end
        while (exp_wr.size() != 0 && obs_wr.size() != 0) begin
            o = obs_wr.pop_front();
            e = exp_wr.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s_write: got addr=%0h wdata=%h wstrb=%b want addr=%0h wdata=%h wstrb=%b",
                         tag, o.addr, o.wdata, o.wstrb, e.addr, e.wdata, e.wstrb);
            end
        end
        exp_wr.delete();
        checks++;
        if (init_done !== 1'b1) begin
            failures++;
            $display("FAIL %s_done: got %0b want 1", tag, init_done);
        end
    endtask

    task automatic test_rx_basic();
        int k;
        logic [7:0] e;
        rx_src.push_back(8'h41);
        exp_rx.push_back(8'h41);
        k = 0;
        while (rx_valid !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (rx_valid !== 1'b1) begin
            failures++;
            $display("FAIL rx_valid: got %0b want 1", rx_valid);
        end
        e = exp_rx.pop_front();
        checks++;
        if (rx_data !== e) begin
            failures++;
            $display("FAIL rx_data: got %h want %h", rx_data, e);
        end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        checks++;
        if (rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL rx_pop_empty: got rx_valid=%0b want 0", rx_valid);
        end
    endtask

    task automatic test_tx();
        int  k, base_rd, base_pulse;
        wr_t o, e;
        obs_wr.delete();
        txrdy_script.push_back(1'b0);
        txrdy_script.push_back(1'b0);
        txrdy_script.push_back(1'b1);
        exp_wr.push_back({3'd4, 32'h0000005A, 4'b0001});
        base_rd    = n_txrdy;
        base_pulse = n_txpulse;
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        k = 0;
        while (tx_ready !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL tx_pulse_timeout: got tx_ready=%0b want 1", tx_ready);
        end
        @(posedge clk);
        #1 tx_valid = 1'b0;
        k = 0;
        while (obs_wr.size() == 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (obs_wr.size() == 0) begin
            failures++;
            $display("FAIL tx_write_timeout: got 0 writes want 1");
        end else begin
            o = obs_wr.pop_front();
            e = exp_wr.pop_front();
            if (o !== e) begin
                failures++;
                $display("FAIL tx_write: got addr=%0h wdata=%h wstrb=%b want addr=%0h wdata=%h wstrb=%b",
                         o.addr, o.wdata, o.wstrb, e.addr, e.wdata, e.wstrb);
            end
        end
        exp_wr.delete();
        repeat (20) @(negedge clk);
        checks++;
        if (n_txpulse - base_pulse != 1) begin
            failures++;
            $display("FAIL tx_pulse_count: got %0d want 1", n_txpulse - base_pulse);
        end
        checks++;
        if (n_txrdy - base_rd != 3) begin
            failures++;
            $display("FAIL tx_poll_count: got %0d want 3", n_txrdy - base_rd);
        end
        checks++;
        if (obs_wr.size() != 0) begin
            failures++;
            $display("FAIL tx_extra_write: got %0d extra writes want 0", obs_wr.size());
        end
    endtask

    task automatic test_fifo_full();
        int k, base;
        logic [7:0] e;
        rx_ready = 1'b0;
        for (int b = 1; b <= 5; b++) begin
            rx_src.push_back(8'(b));
            exp_rx.push_back(8'(b));
        end
        k = 0;
        while (rx_src.size() > 1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        repeat (6) @(negedge clk);
        base = n_rxrdy;
        repeat (40) @(negedge clk);
        checks++;
        if (n_rxrdy != base) begin
            failures++;
            $display("FAIL full_no_poll: got %0d RXREADY polls want 0", n_rxrdy - base);
        end
        checks++;
        if (rx_src.size() != 1) begin
            failures++;
            $display("FAIL full_buffered: got %0d bytes left in UART want 1", rx_src.size());
        end
        for (int i = 0; i < 5; i++) begin
            k = 0;
            while (rx_valid !== 1'b1 && k < 200) begin
                @(negedge clk);
                k++;
            end
            e = exp_rx.pop_front();
            checks++;
            if (rx_valid !== 1'b1 || rx_data !== e) begin
                failures++;
                $display("FAIL full_order: got valid=%0b data=%h want data=%h", rx_valid, rx_data, e);
            end
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
            if (i == 0) begin
                // Let the freed slot be refilled before draining the rest.
                k = 0;
                while (rx_src.size() != 0 && k < 200) begin
                    @(negedge clk);
                    k++;
                end
                repeat (6) @(negedge clk);
            end
        end
        checks++;
        if (rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_drained: got rx_valid=%0b want 0", rx_valid);
        end
    endtask

    task automatic test_stall();
        int  k;
        wr_t snap, o, e;
        obs_wr.delete();
        txrdy_script.push_back(1'b1);
        exp_wr.push_back({3'd4, 32'h000000C3, 4'b0001});
        stall_target = stall_used + 3;
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        k = 0;
        while (tx_ready !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1 tx_valid = 1'b0;
        k = 0;
        while (!(iob_avalid === 1'b1 && iob_wstrb != 4'b0000) && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (iob_avalid !== 1'b1) begin
            failures++;
            $display("FAIL stall_start: got avalid=%0b want 1", iob_avalid);
        end
        snap = {iob_addr, iob_wdata, iob_wstrb};
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if (iob_avalid !== 1'b1 || {iob_addr, iob_wdata, iob_wstrb} !== snap) begin
                failures++;
                $display("FAIL stall_hold: cycle %0d got avalid=%0b addr=%0h wdata=%h wstrb=%b want held",
                         c, iob_avalid, iob_addr, iob_wdata, iob_wstrb);
            end
        end
        @(negedge clk);
        checks++;
        if (iob_avalid !== 1'b0) begin
            failures++;
            $display("FAIL stall_drop: got avalid=%0b want 0", iob_avalid);
        end
        checks++;
        if (obs_wr.size() != 1) begin
            failures++;
            $display("FAIL stall_count: got %0d writes want 1", obs_wr.size());
        end else begin
            o = obs_wr.pop_front();
            e = exp_wr.pop_front();
            if (o !== e) begin
                failures++;
                $display("FAIL stall_write: got addr=%0h wdata=%h wstrb=%b want addr=%0h wdata=%h wstrb=%b",
                         o.addr, o.wdata, o.wstrb, e.addr, e.wdata, e.wstrb);
            end
        end
        exp_wr.delete();
    endtask

    task automatic test_reset_mid();
        int k, base;
        rx_src.push_back(8'h77);
        base = n_rxdata;
        k = 0;
        while (n_rxdata == base && k < 200) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (n_rxdata == base) begin
            failures++;
            $display("FAIL midrst_timeout: got no RXDATA read");
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({iob_avalid, iob_addr, iob_wdata, iob_wstrb} !== 40'h0) begin
            failures++;
            $display("FAIL midrst_bus: got avalid=%0b addr=%0h wdata=%h wstrb=%b want all 0",
                     iob_avalid, iob_addr, iob_wdata, iob_wstrb);
        end
        checks++;
        if ({tx_ready, rx_valid, rx_data, init_done} !== 11'h0) begin
            failures++;
            $display("FAIL midrst_stream: got tx_ready=%0b rx_valid=%0b rx_data=%h init_done=%0b want all 0",
                     tx_ready, rx_valid, rx_data, init_done);
        end
        rx_src.delete();
        exp_rx.delete();
        exp_wr.delete();
        @(negedge clk);
        test_init("restart");
        repeat (10) @(negedge clk);
        checks++;
        if (rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_fifo: got rx_valid=%0b want 0", rx_valid);
        end
    endtask

    initial begin
        test_reset();
        test_init("init");
        test_rx_basic();
        test_tx();
        test_fifo_full();
        test_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
